// File: rtl/job_scheduler.sv
// Job tracker: NUM_JOBS countdown slots driven by START/KILL/SUSPEND/RESUME commands,
// reporting completions and kills as one-cycle done events with a cycle timestamp.
module job_scheduler #(
  parameter int  NUM_JOBS = 5,
  parameter int  CNT_W    = 8,
  parameter int  TIME_W   = 32,
  localparam int ID_W     = $clog2(NUM_JOBS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [ID_W-1:0]       cmd_id,
  input  logic [CNT_W-1:0]      cmd_dur,
  output logic                  cmd_err,
  output logic                  done_valid,
  output logic [ID_W-1:0]       done_id,
  output logic                  done_killed,
  output logic [TIME_W-1:0]     done_time,
  output logic [2*NUM_JOBS-1:0] job_state,
  output logic                  all_idle
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_SUSP = 2'd2;

  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_KILL  = 2'd1;
  localparam logic [1:0] OP_SUSP  = 2'd2;

  logic [1:0]          st_q  [NUM_JOBS];
  logic [1:0]          st_d  [NUM_JOBS];
  logic [CNT_W-1:0]    cnt_q [NUM_JOBS];
  logic [CNT_W-1:0]    cnt_d [NUM_JOBS];
  logic [NUM_JOBS-1:0] pend_q, pend_d, pkill_q, pkill_d;
  logic [NUM_JOBS-1:0] ev_new, ev_kill, ev_all, kill_all, ev_first;
  logic [TIME_W-1:0]   cyc_q;

  logic                id_ok, sel_pend, legal, cmd_go;
  logic [1:0]          sel_st;
  logic                done_hit, done_sel_kill;
  logic [ID_W-1:0]     done_sel;

  // Legality is judged against the addressed slot's state at the start of the cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    id_ok    = 1'b0;
    sel_st   = ST_IDLE;
    sel_pend = 1'b0;
    for (int i = 0; i < NUM_JOBS; i++) begin
      if (cmd_id == ID_W'(i)) begin
        id_ok    = 1'b1;
        sel_st   = st_q[i];
        sel_pend = pend_q[i];
      end
    end
    case (cmd_op)
      OP_START: legal = id_ok && (sel_st == ST_IDLE) && !sel_pend && (cmd_dur != '0);
      OP_KILL:  legal = id_ok && (sel_st != ST_IDLE);
      OP_SUSP:  legal = id_ok && (sel_st == ST_RUN);
      default:  legal = id_ok && (sel_st == ST_SUSP);
    endcase
    cmd_go = cmd_valid && legal;
  end

  // An accepted command for a slot pre-empts that slot's decrement and natural finish.
  always_comb begin
    for (int i = 0; i < NUM_JOBS; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = cnt_q[i];
      ev_new[i]  = 1'b0;
      ev_kill[i] = 1'b0;
      if (cmd_go && (cmd_id == ID_W'(i))) begin
        case (cmd_op)
          OP_START: begin
            st_d[i]  = ST_RUN;
            cnt_d[i] = cmd_dur;
          end
          OP_KILL: begin
            st_d[i]    = ST_IDLE;
            cnt_d[i]   = '0;
            ev_new[i]  = 1'b1;
            ev_kill[i] = 1'b1;
          end
          OP_SUSP: st_d[i] = ST_SUSP;
          default: st_d[i] = ST_RUN;
        endcase
      end else if (st_q[i] == ST_RUN) begin
        if (cnt_q[i] == CNT_W'(1)) begin
          st_d[i]   = ST_IDLE;
          cnt_d[i]  = '0;
          ev_new[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
      end
    end
  end

  // Fixed priority: lowest index among held and fresh events goes out this edge.
  always_comb begin
    ev_all   = pend_q | ev_new;
    kill_all = (pkill_q & ~ev_new) | ev_kill;
    ev_first = ev_all & (~ev_all + NUM_JOBS'(1));
    pend_d   = ev_all & ~ev_first;
    pkill_d  = kill_all & pend_d;
    done_hit      = |ev_all;
    done_sel      = '0;
    done_sel_kill = 1'b0;
    for (int i = NUM_JOBS - 1; i >= 0; i--) begin
      if (ev_all[i]) begin
        done_sel      = ID_W'(i);
        done_sel_kill = kill_all[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slot arrays are reset too; a job alive at reset must never produce an event.
      for (int i = 0; i < NUM_JOBS; i++) begin
        st_q[i]  <= ST_IDLE;
        cnt_q[i] <= '0;
      end
      pend_q      <= '0;
      pkill_q     <= '0;
      cyc_q       <= '0;
      cmd_err     <= 1'b0;
      done_valid  <= 1'b0;
      done_id     <= '0;
      done_killed <= 1'b0;
      done_time   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      for (int i = 0; i < NUM_JOBS; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      pend_q     <= pend_d;
      pkill_q    <= pkill_d;
      cyc_q      <= cyc_q + TIME_W'(1);
      cmd_err    <= cmd_valid && !legal;
      done_valid <= done_hit;
      if (done_hit) begin
        done_id     <= done_sel;
        done_killed <= done_sel_kill;
        done_time   <= cyc_q + TIME_W'(1);
      end
    end
  end

  always_comb begin
    job_state = '0;
    all_idle  = (pend_q == '0);
    for (int i = 0; i < NUM_JOBS; i++) begin
      job_state[2*i +: 2] = st_q[i];
      if (st_q[i] != ST_IDLE) all_idle = 1'b0;
    end
  end

endmodule

// File: tb/tb_job_scheduler.sv
// Bench for job_scheduler: directed scenarios, a command/err vector table,
// and random commands checked cycle-by-cycle against a slot-level reference model.
module tb_job_scheduler;
  localparam int N  = 5;
  localparam int CW = 8;
  localparam int TW = 32;
  localparam int IW = $clog2(N);

  localparam logic [1:0] START = 2'd0;
  localparam logic [1:0] KILL  = 2'd1;
  localparam logic [1:0] SUSP  = 2'd2;
  localparam logic [1:0] RES   = 2'd3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic [1:0]      cmd_op = '0;
  logic [IW-1:0]   cmd_id = '0;
  logic [CW-1:0]   cmd_dur = '0;
  logic            cmd_err, done_valid, done_killed, all_idle;
  logic [IW-1:0]   done_id;
  logic [TW-1:0]   done_time;
  logic [2*N-1:0]  job_state;

  job_scheduler #(.NUM_JOBS(N), .CNT_W(CW), .TIME_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_id(cmd_id), .cmd_dur(cmd_dur), .cmd_err(cmd_err),
    .done_valid(done_valid), .done_id(done_id), .done_killed(done_killed),
    .done_time(done_time), .job_state(job_state), .all_idle(all_idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: slot status, remaining running cycles, pending events.
  int     m_state [N];   // 0 idle, 1 running, 2 suspended
  int     m_rem   [N];
  bit     m_pend  [N];
  bit     m_pkill [N];
  longint m_cyc;
  bit     m_err, m_dv, m_dk;
  int     m_did;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_state[i] = 0; m_rem[i] = 0; m_pend[i] = 0; m_pkill[i] = 0;
    end
    m_cyc = 0; m_err = 0; m_dv = 0; m_dk = 0; m_did = 0;
  endtask

  task automatic model_step(input bit v, input logic [1:0] op, input int id, input int dur);
    bit ok;
    ok = 0;
    if (v && id < N) begin
      case (op)
        START:   ok = (m_state[id] == 0) && !m_pend[id] && (dur != 0);
        KILL:    ok = (m_state[id] != 0);
        SUSP:    ok = (m_state[id] == 1);
        default: ok = (m_state[id] == 2);
      endcase
    end
    m_err = v && !ok;
    for (int i = 0; i < N; i++) begin
      if (ok && id == i) begin
        case (op)
          START:   begin m_state[i] = 1; m_rem[i] = dur; end
          KILL:    begin m_state[i] = 0; m_pend[i] = 1; m_pkill[i] = 1; end
          SUSP:    m_state[i] = 2;
          default: m_state[i] = 1;
        endcase
      end else if (m_state[i] == 1) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_state[i] = 0; m_pend[i] = 1; m_pkill[i] = 0;
        end
      end
    end
    m_dv = 0;
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && !m_dv) begin
        m_dv = 1; m_did = i; m_dk = m_pkill[i]; m_pend[i] = 0;
      end
    end
    m_cyc++;
  endtask

  task automatic compare_model();
    logic [2*N-1:0] s;
    bit idle;
    idle = 1;
    for (int i = 0; i < N; i++) begin
      s[2*i +: 2] = 2'(m_state[i]);
      if (m_state[i] != 0 || m_pend[i]) idle = 0;
    end
    check("model_cmd_err", cmd_err, m_err);
    check("model_done_valid", done_valid, m_dv);
    check("model_job_state", job_state, s);
    check("model_all_idle", all_idle, idle);
    if (m_dv && done_valid) begin
      check("model_done_id", done_id, m_did);
      check("model_done_killed", done_killed, m_dk);
      check("model_done_time", done_time, m_cyc % (64'd1 << TW));
    end
  endtask

  // Drive one command for the current cycle, advance to the next, compare against the model.
  task automatic cycle(input bit v, input logic [1:0] op, input int id, input int dur);
    cmd_valid = v; cmd_op = op; cmd_id = IW'(id); cmd_dur = CW'(dur);
    model_step(v, op, id, dur);
    @(negedge clk);
    cmd_valid = 1'b0;
    compare_model();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, START, 0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_err"}, cmd_err, 0);
    check({tag, "_done_valid"}, done_valid, 0);
    check({tag, "_done_id"}, done_id, 0);
    check({tag, "_done_killed"}, done_killed, 0);
    check({tag, "_done_time"}, done_time, 0);
    check({tag, "_job_state"}, job_state, 0);
    check({tag, "_all_idle"}, all_idle, 1);
  endtask

  // Assert reset mid-cycle, hold for two cycles, release on a falling edge (start of cycle 0).
  task automatic do_reset(input string tag);
    rst_n = 1'b0; cmd_valid = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [1:0]     op;
    int             id;
    int             dur;
    logic           exp_err;
    logic [2*N-1:0] exp_state;
  } vec_t;

  vec_t vecs [11];
  bit   seen;

  initial begin
    vecs[0]  = '{START, 1, 50, 1'b0, 10'b00_0000_0100};
    vecs[1]  = '{START, 1, 3,  1'b1, 10'b00_0000_0100};
    vecs[2]  = '{START, 5, 3,  1'b1, 10'b00_0000_0100};
    vecs[3]  = '{START, 2, 0,  1'b1, 10'b00_0000_0100};
    vecs[4]  = '{RES,   3, 0,  1'b1, 10'b00_0000_0100};
    vecs[5]  = '{KILL,  0, 0,  1'b1, 10'b00_0000_0100};
    vecs[6]  = '{SUSP,  2, 0,  1'b1, 10'b00_0000_0100};
    vecs[7]  = '{SUSP,  1, 0,  1'b0, 10'b00_0000_1000};
    vecs[8]  = '{SUSP,  1, 0,  1'b1, 10'b00_0000_1000};
    vecs[9]  = '{RES,   1, 0,  1'b0, 10'b00_0000_0100};
    vecs[10] = '{KILL,  1, 0,  1'b0, 10'b00_0000_0000};

    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // Staggered starts: slot k, D=k+1, in cycle k.
    for (int c = 0; c < 12; c++) begin
      if (c < 5) cycle(1'b1, START, c, c + 1);
      else idle_cycle();
      if ((c + 1) % 2 == 0 && c + 1 <= 10) begin
        check("stag_dv", done_valid, 1);
        check("stag_id", done_id, (c + 1) / 2 - 1);
        check("stag_time", done_time, c + 1);
        check("stag_killed", done_killed, 0);
      end else begin
        check("stag_dv_quiet", done_valid, 0);
      end
      if (c + 1 == 9) check("stag_busy9", all_idle, 0);
      if (c + 1 >= 10) check("stag_idle", all_idle, 1);
    end

    // Three slots finishing on the same edge drain one per cycle, lowest first.
    do_reset("rst1");
    cycle(1'b1, START, 2, 4);
    cycle(1'b1, START, 0, 3);
    cycle(1'b1, START, 1, 2);
    for (int c = 3; c < 9; c++) begin
      idle_cycle();
      check("tie_dv", done_valid, (c + 1 >= 5 && c + 1 <= 7));
      if (c + 1 >= 5 && c + 1 <= 7) check("tie_id", done_id, c + 1 - 5);
    end

    // Suspend/resume stretches the job.
    do_reset("rst2");
    cycle(1'b1, START, 0, 5);
    idle_cycle();
    cycle(1'b1, SUSP, 0, 0);
    while (m_cyc < 10) begin
      check("susp_state", job_state[1:0], 2);
      idle_cycle();
    end
    check("susp_state10", job_state[1:0], 2);
    cycle(1'b1, RES, 0, 0);
    check("res_state11", job_state[1:0], 1);
    for (int c = 11; c < 17; c++) begin
      idle_cycle();
      check("res_dv", done_valid, (c + 1 == 15));
      if (c + 1 == 15) check("res_id", done_id, 0);
    end

    // Kill mid-run.
    do_reset("rst3");
    cycle(1'b1, START, 3, 20);
    repeat (4) idle_cycle();
    cycle(1'b1, KILL, 3, 0);
    check("kill_dv", done_valid, 1);
    check("kill_id", done_id, 3);
    check("kill_flag", done_killed, 1);
    check("kill_time", done_time, 6);
    seen = 0;
    repeat (25) begin
      idle_cycle();
      if (done_valid) seen = 1;
    end
    check("kill_no_more", seen, 0);

    // Illegal/legal command table.
    do_reset("rst4");
    for (int k = 0; k < 11; k++) begin
      cycle(1'b1, vecs[k].op, vecs[k].id, vecs[k].dur);
      check($sformatf("vec%0d_err", k), cmd_err, vecs[k].exp_err);
      check($sformatf("vec%0d_state", k), job_state, vecs[k].exp_state);
    end
    idle_cycle();

    // Reset mid-job: no stale events, cycle counter restarts.
    do_reset("rst5");
    cycle(1'b1, START, 0, 10);
    cycle(1'b1, START, 1, 10);
    idle_cycle();
    idle_cycle();
    do_reset("midrst");
    seen = 0;
    repeat (20) begin
      idle_cycle();
      if (done_valid) seen = 1;
    end
    check("midrst_no_done", seen, 0);
    cycle(1'b1, START, 0, 1);
    idle_cycle();
    check("midrst_dv", done_valid, 1);
    check("midrst_time", done_time, 22);

    // Random commands against the model.
    do_reset("rst6");
    for (int c = 0; c < 2000; c++) begin
      bit v;
      v = ($urandom_range(0, 3) != 0);
      cycle(v, 2'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
